// File: rtl/hazard_pkg.sv
// Shared definitions for the ID-stage hazard controller.
//   md_state_e      : mul/div hold sequencer state encoding
//   REG_ZERO        : architectural zero register, never a real dependency
//   STALL_CNT_W     : default width of the stall cycle counter
//   MULDIV_LATENCY  : default cycles a mul/div occupies EX
//   reg_match()     : does a producer register feed the ID instruction?
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDrain = 2'd2
  } md_state_e;

  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned STALL_CNT_W    = 16;
  localparam int unsigned MULDIV_LATENCY = 4;

  // rt only counts as a source when the ID instruction actually reads it.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/muldiv_hold_fsm.sv
// Holds a multi-cycle mul/div in EX for exactly MulDivLatency cycles.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset, aborts any op in flight
//   start_i  : EX instruction is mul/div (ignored while draining)
//   hold_o   : freeze EX; high for the first MulDivLatency-1 cycles of the op
//   done_o   : mul/div result valid in EX this cycle (last cycle of the op)
module muldiv_hold_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MulDivLatency = MULDIV_LATENCY  // legal range 2..16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic hold_o,
  output logic done_o
);

  localparam logic [3:0] CntInit = 4'(MulDivLatency - 2);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d   = CntInit;
          // Two-cycle ops skip BUSY: one hold cycle, then the result cycle.
          state_d = (MulDivLatency == 2) ? StDrain : StBusy;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDrain;
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hold_o = 1'b0;
    done_o = 1'b0;
    unique case (state_q)
      StIdle:  hold_o = start_i;
      StBusy:  hold_o = 1'b1;
      StDrain: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller for the 5-stage MIPS pipeline. Detects hazards that
// forwarding cannot cover (load-use, branch operands compared in ID), holds EX for
// multi-cycle mul/div and counts cycles in which the PC is frozen.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   mem_read_ex_i        : EX instruction is a load
//   reg_write_ex_i       : EX instruction writes the register file
//   rd_ex_i              : EX destination register
//   mem_read_mem_i       : MEM instruction is a load
//   rd_mem_i             : MEM destination register
//   rs_id_i, rt_id_i     : ID source fields
//   uses_rt_id_i         : ID instruction reads rt
//   branch_id_i          : ID instruction is a branch compared in ID
//   branch_taken_id_i    : that branch resolves taken this cycle
//   muldiv_start_ex_i    : EX instruction is mul/div
//   pc_write_o           : PC load enable
//   ifid_write_o         : IF/ID load enable
//   ifid_flush_o         : zero IF/ID at next edge
//   idex_bubble_o        : zero ID/EX control at next edge
//   ex_hold_o            : freeze ID/EX
//   exmem_bubble_o       : zero EX/MEM control at next edge
//   muldiv_done_o        : mul/div result valid in EX
//   stall_count_o        : saturating count of cycles with pc_write_o low
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MulDivLatency = MULDIV_LATENCY,
  parameter int unsigned StallCntW     = STALL_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_read_ex_i,
  input  logic                 reg_write_ex_i,
  input  logic [4:0]           rd_ex_i,
  input  logic                 mem_read_mem_i,
  input  logic [4:0]           rd_mem_i,
  input  logic [4:0]           rs_id_i,
  input  logic [4:0]           rt_id_i,
  input  logic                 uses_rt_id_i,
  input  logic                 branch_id_i,
  input  logic                 branch_taken_id_i,
  input  logic                 muldiv_start_ex_i,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 ifid_flush_o,
  output logic                 idex_bubble_o,
  output logic                 ex_hold_o,
  output logic                 exmem_bubble_o,
  output logic                 muldiv_done_o,
  output logic [StallCntW-1:0] stall_count_o
);

  logic match_ex, match_mem, load_use, br_haz, stall;
  logic hold, fsm_done;
  logic [StallCntW-1:0] stall_cnt_q, stall_cnt_d;

  assign match_ex  = reg_match(rd_ex_i, rs_id_i, rt_id_i, uses_rt_id_i);
  assign match_mem = reg_match(rd_mem_i, rs_id_i, rt_id_i, uses_rt_id_i);
  assign load_use  = mem_read_ex_i && match_ex;
  // Branch compares in ID need values that the forwarding path only reaches in EX.
  assign br_haz    = branch_id_i && ((reg_write_ex_i && match_ex) ||
                                     (mem_read_mem_i && match_mem));
  assign stall     = load_use || br_haz;

  muldiv_hold_fsm #(
    .MulDivLatency(MulDivLatency)
  ) u_muldiv_hold_fsm (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(muldiv_start_ex_i),
    .hold_o (hold),
    .done_o (fsm_done)
  );

  // Hold beats stall beats flush: a taken branch seen while frozen resolves again later.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    ex_hold_o      = 1'b0;
    exmem_bubble_o = 1'b0;
    muldiv_done_o  = fsm_done;
    if (rst_i) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_bubble_o  = 1'b1;
      exmem_bubble_o = 1'b1;
      muldiv_done_o  = 1'b0;
    end else if (hold) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ex_hold_o      = 1'b1;
      exmem_bubble_o = 1'b1;
    end else if (stall) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_id_i) begin
      ifid_flush_o = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + StallCntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic        clk, rst;
  logic        mem_read_ex, reg_write_ex, mem_read_mem, uses_rt_id;
  logic        branch_id, branch_taken_id, muldiv_start_ex;
  logic [4:0]  rd_ex, rd_mem, rs_id, rt_id;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble;
  logic        muldiv_done;
  logic [15:0] stall_count;
  logic [6:0]  ctl;

  int errors = 0;
  int checks = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble, muldiv_done}
  localparam logic [6:0] CtlReset    = 7'b0001010;
  localparam logic [6:0] CtlRun      = 7'b1100000;
  localparam logic [6:0] CtlStall    = 7'b0001000;
  localparam logic [6:0] CtlFlush    = 7'b1110000;
  localparam logic [6:0] CtlHold     = 7'b0000110;
  localparam logic [6:0] CtlDone     = 7'b1100001;
  localparam logic [6:0] CtlDoneStal = 7'b0001001;

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble,
                muldiv_done};

  hazard_detection_unit #(
    .MulDivLatency(4),
    .StallCntW    (16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .mem_read_ex_i    (mem_read_ex),
    .reg_write_ex_i   (reg_write_ex),
    .rd_ex_i          (rd_ex),
    .mem_read_mem_i   (mem_read_mem),
    .rd_mem_i         (rd_mem),
    .rs_id_i          (rs_id),
    .rt_id_i          (rt_id),
    .uses_rt_id_i     (uses_rt_id),
    .branch_id_i      (branch_id),
    .branch_taken_id_i(branch_taken_id),
    .muldiv_start_ex_i(muldiv_start_ex),
    .pc_write_o       (pc_write),
    .ifid_write_o     (ifid_write),
    .ifid_flush_o     (ifid_flush),
    .idex_bubble_o    (idex_bubble),
    .ex_hold_o        (ex_hold),
    .exmem_bubble_o   (exmem_bubble),
    .muldiv_done_o    (muldiv_done),
    .stall_count_o    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    mem_read_ex = 0; reg_write_ex = 0; mem_read_mem = 0; uses_rt_id = 0;
    branch_id = 0; branch_taken_id = 0; muldiv_start_ex = 0;
    rd_ex = 0; rd_mem = 0; rs_id = 0; rt_id = 0;
  endtask

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    branch_taken_id = 1;
    muldiv_start_ex = 1;
    #1;
    checks++;
    if (ctl !== CtlReset) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CtlReset);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", stall_count);
    end
    @(negedge clk);
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    mem_read_ex = 1; rd_ex = 8; rs_id = 8;
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, CtlStall);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL load_use_release: got %b expected %b", ctl, CtlRun);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    mem_read_ex = 1; rd_ex = 0; rs_id = 0;
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL zero_reg_r0: got %b expected %b", ctl, CtlRun);
    end
    @(negedge clk);
    rd_ex = 9; rt_id = 9; rs_id = 3; uses_rt_id = 0;
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL zero_reg_rt_unused: got %b expected %b", ctl, CtlRun);
    end
    @(negedge clk);
    uses_rt_id = 1;
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL load_use_rt: got %b expected %b", ctl, CtlStall);
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_id = 1; rs_id = 5; reg_write_ex = 1; rd_ex = 5;
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL branch_ex: got %b expected %b", ctl, CtlStall);
    end
    @(negedge clk);
    reg_write_ex = 0; rd_ex = 0; mem_read_mem = 1; rd_mem = 5;
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL branch_mem: got %b expected %b", ctl, CtlStall);
    end
    @(negedge clk);
    branch_id = 0;
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL nonbranch_mem: got %b expected %b", ctl, CtlRun);
    end
    @(negedge clk);
    branch_id = 1; branch_taken_id = 1;
    #1;
    checks++;
    if (ctl !== CtlStall) begin
      errors++; $display("FAIL taken_in_stall: got %b expected %b", ctl, CtlStall);
    end
    @(negedge clk);
    mem_read_mem = 0; rd_mem = 0;
    #1;
    checks++;
    if (ctl !== CtlFlush) begin
      errors++; $display("FAIL branch_flush: got %b expected %b", ctl, CtlFlush);
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++; $display("FAIL branch_count: got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_muldiv();
    logic [4:0] hold_exp;
    logic [4:0] done_exp;
    hold_exp = 5'b00111;
    done_exp = 5'b01000;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      muldiv_start_ex = (c < 4);
      #1;
      checks++;
      if (ex_hold !== hold_exp[c] || muldiv_done !== done_exp[c]) begin
        errors++;
        $display("FAIL muldiv_cycle%0d: got hold=%b done=%b expected hold=%b done=%b",
                 c, ex_hold, muldiv_done, hold_exp[c], done_exp[c]);
      end
      @(negedge clk);
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++; $display("FAIL muldiv_count: got %0d expected 3", stall_count);
    end
  endtask

  task automatic test_priority();
    do_reset();
    muldiv_start_ex = 1;
    @(negedge clk);
    mem_read_ex = 1; rd_ex = 8; rs_id = 8; branch_id = 1; branch_taken_id = 1;
    #1;
    checks++;
    if (ctl !== CtlHold) begin
      errors++; $display("FAIL prio_busy: got %b expected %b", ctl, CtlHold);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== CtlDoneStal) begin
      errors++; $display("FAIL prio_drain_stall: got %b expected %b", ctl, CtlDoneStal);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL prio_idle: got %b expected %b", ctl, CtlRun);
    end
  endtask

  task automatic test_drain_plain();
    do_reset();
    muldiv_start_ex = 1;
    repeat (3) @(negedge clk);
    muldiv_start_ex = 0;
    #1;
    checks++;
    if (ctl !== CtlDone) begin
      errors++; $display("FAIL drain_plain: got %b expected %b", ctl, CtlDone);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    muldiv_start_ex = 1;
    @(negedge clk);
    @(negedge clk);
    // Now in BUSY with cnt==1; next cycle would be DRAIN.
    rst = 1;
    muldiv_start_ex = 0;
    #1;
    checks++;
    if (ctl !== CtlReset) begin
      errors++; $display("FAIL abort_in_reset: got %b expected %b", ctl, CtlReset);
    end
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ctl !== CtlRun) begin
      errors++; $display("FAIL abort_no_done: got %b expected %b", ctl, CtlRun);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_read_ex = 1; rd_ex = 8; rs_id = 8;
    repeat (65534) @(posedge clk);
    #1;
    checks++;
    if (stall_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_near: got %h expected fffe", stall_count);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (stall_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h expected ffff", stall_count);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_muldiv();
    test_priority();
    test_drain_plain();
    test_reset_abort();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
